// File: rtl/sort_mem_scheduler.sv
// Run sequencer for a bubble-sort engine: hands a single-port data memory between
// the host loader and the sorter, issues start/abort pulses and tracks run outcome.
module sort_mem_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    input  logic              host_sort_req,
    input  logic              srt_rd,
    input  logic              srt_wr,
    input  logic [ADDR_W-1:0] srt_addr,
    input  logic [DATA_W-1:0] srt_wdata,
    input  logic              srt_done,
    output logic              srt_start,
    output logic              srt_abort,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              sort_done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  run_count
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_SORT   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WD_W-1:0]  r_wd;
    logic             r_abort;
    logic             r_sort_done;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_run_count;

    logic             w_launch;
    logic             w_finish_ok;
    logic             w_finish_to;

    // srt_done wins over the watchdog when both land in the same SORT cycle
    assign w_launch    = (r_state == S_IDLE) && host_sort_req;
    assign w_finish_ok = (r_state == S_SORT) && srt_done;
    assign w_finish_to = (r_state == S_SORT) && !srt_done && (r_wd == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (host_sort_req) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_SORT;
            S_SORT:   if (srt_done || (r_wd == WD_LAST)) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd          <= '0;
            r_abort       <= 1'b0;
            r_sort_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_run_count   <= '0;
        end else begin
            r_abort <= w_finish_to;
            if (r_state == S_LAUNCH) begin
                r_wd <= '0;
            end else if (r_state == S_SORT) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_launch) begin
                r_sort_done   <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_finish_ok) begin
                r_sort_done <= 1'b1;
                r_run_count <= r_run_count + CNT_W'(1);
            end
            if (w_finish_to) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Memory ownership follows the current state with no added latency
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                mem_rd    = host_req & ~host_wr;
                mem_wr    = host_req & host_wr;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            S_SORT: begin
                mem_rd    = srt_rd;
                mem_wr    = srt_wr;
                mem_addr  = srt_addr;
                mem_wdata = srt_wdata;
            end
            default: begin
                mem_rd    = 1'b0;
                mem_wr    = 1'b0;
            end
        endcase
    end

    assign host_gnt    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign srt_start   = (r_state == S_LAUNCH);
    assign srt_abort   = r_abort;
    assign sort_done   = r_sort_done;
    assign timeout_err = r_timeout_err;
    assign run_count   = r_run_count;

endmodule

// File: tb/tb_sort_mem_scheduler.sv
// Bench for sort_mem_scheduler: vector table for host muxing, directed run sequences,
// then randomized traffic against a cycle-counting run model.
module tb_sort_mem_scheduler;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int TO      = 8;
    localparam int CNT_W   = 2;

    logic              clk;
    logic              rst;
    logic              host_req;
    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_sort_req;
    logic              srt_rd;
    logic              srt_wr;
    logic [ADDR_W-1:0] srt_addr;
    logic [DATA_W-1:0] srt_wdata;
    logic              srt_done;
    logic              srt_start;
    logic              srt_abort;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              sort_done;
    logic              timeout_err;
    logic [CNT_W-1:0]  run_count;

    sort_mem_scheduler #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TO),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_req     (host_req),
        .host_wr      (host_wr),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_sort_req(host_sort_req),
        .srt_rd       (srt_rd),
        .srt_wr       (srt_wr),
        .srt_addr     (srt_addr),
        .srt_wdata    (srt_wdata),
        .srt_done     (srt_done),
        .srt_start    (srt_start),
        .srt_abort    (srt_abort),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .sort_done    (sort_done),
        .timeout_err  (timeout_err),
        .run_count    (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_req = 0; host_wr = 0; host_addr = 0; host_wdata = 0; host_sort_req = 0;
        srt_rd = 0; srt_wr = 0; srt_addr = 0; srt_wdata = 0; srt_done = 0;
    endtask

    typedef struct {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              s_rd;
        logic              s_wr;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_wdata;
        logic              e_rd;
        logic              e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
    } vec_t;

    vec_t tbl[18];

    // Run model: position counted in cycles from the LAUNCH cycle
    bit m_run;
    int m_t;
    int m_end;
    bit m_done;
    bit m_terr;
    bit m_ab;
    int m_cnt;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_end = -1; m_done = 0; m_terr = 0; m_ab = 0; m_cnt = 0;
    endtask

    function automatic bit m_is_launch();
        return m_run && (m_t == 0);
    endfunction

    function automatic bit m_is_drain();
        return m_run && (m_end >= 0) && (m_t == m_end);
    endfunction

    function automatic bit m_is_sort();
        return m_run && (m_t >= 1) && (m_end < 0);
    endfunction

    task automatic model_step();
        if (!m_run) begin
            if (host_sort_req) begin
                m_run = 1; m_t = 0; m_end = -1; m_done = 0; m_terr = 0; m_ab = 0;
            end
        end else if (m_is_drain()) begin
            m_run = 0; m_ab = 0;
        end else begin
            if (m_t >= 1) begin
                if (srt_done) begin
                    m_end = m_t + 1; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end else if (m_t == TO) begin
                    m_end = m_t + 1; m_terr = 1; m_ab = 1;
                end
            end
            m_t++;
        end
    endtask

    initial begin
        logic e_rd, e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 1'b1, ADDR_W'(i), DATA_W'(15 - i), 1'b1, 1'b1, ADDR_W'(15 - i),
                       8'hC3, 1'b0, 1'b1, ADDR_W'(i), DATA_W'(15 - i)};
        end
        tbl[16] = '{1'b1, 1'b0, 4'd3, 8'h77, 1'b1, 1'b0, 4'd9, 8'h11, 1'b1, 1'b0, 4'd3, 8'h77};
        tbl[17] = '{1'b0, 1'b1, 4'd6, 8'h5A, 1'b0, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 4'd6, 8'h5A};

        // Reset with random inputs
        rst = 0;
        host_req = 1'($urandom); host_wr = 1'($urandom); host_addr = 4'($urandom);
        host_wdata = 8'($urandom); host_sort_req = 1; srt_rd = 1'($urandom);
        srt_wr = 1'($urandom); srt_addr = 4'($urandom); srt_wdata = 8'($urandom); srt_done = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_host_gnt", host_gnt, 1);
        chk("rst_busy", busy, 0);
        chk("rst_srt_start", srt_start, 0);
        chk("rst_srt_abort", srt_abort, 0);
        chk("rst_sort_done", sort_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_run_count", run_count, 0);
        idle_inputs();
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        step();
        rst = 1;

        // Host load and readback in IDLE
        foreach (tbl[i]) begin
            host_req = tbl[i].req; host_wr = tbl[i].wr; host_addr = tbl[i].addr;
            host_wdata = tbl[i].wdata; srt_rd = tbl[i].s_rd; srt_wr = tbl[i].s_wr;
            srt_addr = tbl[i].s_addr; srt_wdata = tbl[i].s_wdata;
            #1;
            chk($sformatf("load%0d_rd", i), mem_rd, tbl[i].e_rd);
            chk($sformatf("load%0d_wr", i), mem_wr, tbl[i].e_wr);
            chk($sformatf("load%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("load%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
            chk($sformatf("load%0d_gnt", i), host_gnt, 1);
            step();
        end
        idle_inputs();

        // Launch, sorter access, contention, normal completion
        host_sort_req = 1;
        step();
        host_sort_req = 0;
        chk("launch_start", srt_start, 1);
        chk("launch_gnt", host_gnt, 0);
        chk("launch_busy", busy, 1);
        step();
        chk("sort_start_low", srt_start, 0);
        step();
        srt_wr = 1; srt_addr = 5; srt_wdata = 8'hAA;
        #1;
        chk("sort_mem_wr", mem_wr, 1);
        chk("sort_mem_addr", mem_addr, 5);
        chk("sort_mem_wdata", mem_wdata, 8'hAA);
        srt_wr = 0; host_req = 1; host_wr = 1; host_addr = 9; host_wdata = 8'h33; host_sort_req = 1;
        #1;
        chk("contend_mem_wr", mem_wr, 0);
        chk("contend_gnt", host_gnt, 0);
        step();
        chk("contend_no_restart", srt_start, 0);
        host_req = 0; host_wr = 0; host_sort_req = 0;
        repeat (4) step();
        srt_done = 1;
        step();
        srt_done = 0; srt_wr = 1; srt_addr = 5; host_req = 1; host_wr = 1;
        #1;
        chk("drain_busy", busy, 1);
        chk("drain_mem_wr", mem_wr, 0);
        chk("drain_mem_addr", mem_addr, 0);
        chk("drain_sort_done", sort_done, 1);
        chk("drain_run_count", run_count, 1);
        chk("drain_abort", srt_abort, 0);
        idle_inputs();
        step();
        chk("post_busy", busy, 0);
        chk("post_gnt", host_gnt, 1);
        chk("post_run_count", run_count, 1);

        // Watchdog timeout
        host_sort_req = 1;
        step();
        host_sort_req = 0;
        for (int i = 0; i < TO; i++) begin
            step();
            chk($sformatf("to_sort%0d_abort", i), srt_abort, 0);
            chk($sformatf("to_sort%0d_busy", i), busy, 1);
        end
        step();
        chk("to_abort", srt_abort, 1);
        chk("to_err", timeout_err, 1);
        chk("to_sort_done", sort_done, 0);
        chk("to_run_count", run_count, 1);
        chk("to_drain_busy", busy, 1);
        step();
        chk("to_abort_clear", srt_abort, 0);
        chk("to_idle", busy, 0);
        chk("to_err_sticky", timeout_err, 1);
        host_sort_req = 1;
        step();
        host_sort_req = 0;
        chk("relaunch_err_clr", timeout_err, 0);
        step();
        srt_done = 1;
        step();
        srt_done = 0;
        step();
        chk("relaunch_count", run_count, 2);
        chk("relaunch_done", sort_done, 1);

        // Asynchronous reset in the middle of SORT
        host_sort_req = 1;
        step();
        host_sort_req = 0;
        step();
        chk("pre_rst_busy", busy, 1);
        #1 rst = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_gnt", host_gnt, 1);
        chk("midrst_count", run_count, 0);
        chk("midrst_done", sort_done, 0);
        chk("midrst_start", srt_start, 0);
        step();
        rst = 1;

        // Counter wrap with CNT_W=2
        for (int k = 0; k < 4; k++) begin
            host_sort_req = 1;
            step();
            host_sort_req = 0;
            step();
            srt_done = 1;
            step();
            srt_done = 0;
            step();
            chk($sformatf("wrap_run%0d", k), run_count, (k + 1) % 4);
        end

        // Randomized traffic against the run model
        rst = 0;
        step();
        rst = 1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            host_req = 1'($urandom); host_wr = 1'($urandom);
            host_addr = 4'($urandom); host_wdata = 8'($urandom);
            host_sort_req = ($urandom_range(0, 3) == 0);
            srt_rd = 1'($urandom); srt_wr = 1'($urandom);
            srt_addr = 4'($urandom); srt_wdata = 8'($urandom);
            srt_done = ($urandom_range(0, 11) == 0);
            #1;
            if (!m_run) begin
                e_rd = host_req & ~host_wr; e_wr = host_req & host_wr;
                e_addr = host_addr; e_wdata = host_wdata;
            end else if (m_is_sort()) begin
                e_rd = srt_rd; e_wr = srt_wr; e_addr = srt_addr; e_wdata = srt_wdata;
            end else begin
                e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
            end
            chk("rnd_mem_rd", mem_rd, e_rd);
            chk("rnd_mem_wr", mem_wr, e_wr);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_wdata);
            chk("rnd_host_gnt", host_gnt, !m_run);
            chk("rnd_busy", busy, m_run);
            chk("rnd_srt_start", srt_start, m_is_launch());
            chk("rnd_srt_abort", srt_abort, m_is_drain() && m_ab);
            chk("rnd_sort_done", sort_done, m_done);
            chk("rnd_timeout_err", timeout_err, m_terr);
            chk("rnd_run_count", run_count, m_cnt);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
